output_matrix_eth_streamer: RTL and testbench

Ethernet-domain read-out stage for the Output_Matrix dual-port BRAM. It sits on port B (eth_refclk side): on a start pulse it reads the requested number of rows, each row being MAX_SIZE_A elements of MAX_ELEMENT_SIZE bits. It serializes each row into an 8-bit valid/ready byte stream for the Ethernet transmit framer, flagging the final byte of the matrix. It owns port B exclusively and never writes.

---
 rtl/output_matrix_pkg.sv | 21 ++
 rtl/row_byte_serializer.sv | 60 ++++++
 rtl/output_matrix_eth_streamer.sv | 119 +++++++++++
 tb/tb_output_matrix_eth_streamer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/output_matrix_pkg.sv
// Shared definitions for the Output_Matrix BRAM readers/writers: size defaults,
// FSM state encoding and the row-to-byte derivation.
package output_matrix_pkg;

  localparam int unsigned DEF_MAX_SIZE_A       = 8;
  localparam int unsigned DEF_MAX_SIZE_B       = 8;
  localparam int unsigned DEF_MAX_ELEMENT_SIZE = 8;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRead = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StLoad = 3'd3;
  localparam logic [2:0] StSend = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  function automatic int unsigned row_bytes(input int unsigned size_a,
                                            input int unsigned elem_size);
    return (size_a * elem_size) / 8;
  endfunction

endpackage

// File: rtl/row_byte_serializer.sv
// Loadable row shift register that drains one byte per valid/ready handshake,
// least-significant byte first.
module row_byte_serializer #(
  parameter int unsigned RowW     = 64,
  parameter int unsigned RowBytes = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [RowW-1:0] row_i,
  input  logic            tready_i,
  output logic [7:0]      tdata_o,
  output logic            tvalid_o,
  output logic            last_byte_o,
  output logic            fire_o
);

  localparam int unsigned CntW = (RowBytes > 1) ? $clog2(RowBytes) : 1;

  logic [RowW-1:0] shreg_q, shreg_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;

  assign tdata_o     = shreg_q[7:0];
  assign tvalid_o    = valid_q;
  assign last_byte_o = (cnt_q == CntW'(RowBytes - 1));
  assign fire_o      = valid_q & tready_i;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      shreg_d = row_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (fire_o) begin
      shreg_d = shreg_q >> 8;
      if (last_byte_o) begin
        cnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/output_matrix_eth_streamer.sv
// Port-B reader of the Output_Matrix BRAM: fetches the requested rows and streams
// them as bytes to the Ethernet framer, tagging the final byte of the matrix.
module output_matrix_eth_streamer
  import output_matrix_pkg::*;
#(
  parameter int unsigned MAX_SIZE_A       = DEF_MAX_SIZE_A,
  parameter int unsigned MAX_SIZE_B       = DEF_MAX_SIZE_B,
  parameter int unsigned MAX_ELEMENT_SIZE = DEF_MAX_ELEMENT_SIZE,
  parameter int unsigned ADDR_W           = $clog2(MAX_SIZE_B)
) (
  input  logic                                   eth_refclk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [ADDR_W:0]                        num_rows,
  output logic                                   busy,
  output logic                                   done,
  output logic [ADDR_W-1:0]                      addr_eth,
  output logic                                   en_eth,
  output logic                                   we_eth,
  output logic [MAX_SIZE_A*MAX_ELEMENT_SIZE-1:0] din_eth,
  output logic                                   regce_eth,
  input  logic [MAX_SIZE_A*MAX_ELEMENT_SIZE-1:0] dout_eth,
  output logic [7:0]                             m_tdata,
  output logic                                   m_tvalid,
  input  logic                                   m_tready,
  output logic                                   m_tlast
);

  localparam int unsigned RowW     = MAX_SIZE_A * MAX_ELEMENT_SIZE;
  localparam int unsigned RowBytes = row_bytes(MAX_SIZE_A, MAX_ELEMENT_SIZE);
  localparam logic [ADDR_W:0] MaxRows = (ADDR_W + 1)'(MAX_SIZE_B);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   rows_q, rows_d;
  logic [ADDR_W-1:0] row_idx_q, row_idx_d;
  logic              load;
  logic              fire;
  logic              last_byte;
  logic              last_row;

  assign last_row = (({1'b0, row_idx_q} + (ADDR_W + 1)'(1)) == rows_q);

  row_byte_serializer #(
    .RowW     (RowW),
    .RowBytes (RowBytes)
  ) u_serializer (
    .clk_i       (eth_refclk),
    .rst_i       (rst),
    .load_i      (load),
    .row_i       (dout_eth),
    .tready_i    (m_tready),
    .tdata_o     (m_tdata),
    .tvalid_o    (m_tvalid),
    .last_byte_o (last_byte),
    .fire_o      (fire)
  );

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    row_idx_d = row_idx_q;
    load      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (num_rows == '0) begin
            state_d = StDone;
          end else begin
            // Clamping here is what keeps row_idx inside the BRAM depth.
            rows_d    = (num_rows > MaxRows) ? MaxRows : num_rows;
            row_idx_d = '0;
            state_d   = StRead;
          end
        end
      end
      StRead: state_d = StWait;
      StWait: state_d = StLoad;
      StLoad: begin
        load    = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (fire && last_byte) begin
          if (last_row) begin
            state_d = StDone;
          end else begin
            row_idx_d = row_idx_q + ADDR_W'(1);
            state_d   = StRead;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge eth_refclk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rows_q    <= '0;
      row_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      row_idx_q <= row_idx_d;
    end
  end

  // Every output below is decoded from registered state; m_tready never reaches them.
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign en_eth    = (state_q == StRead);
  assign regce_eth = (state_q == StWait);
  assign addr_eth  = row_idx_q;
  assign m_tlast   = m_tvalid & last_byte & last_row;
  assign we_eth    = 1'b0;
  assign din_eth   = '0;

endmodule

// File: tb/tb_output_matrix_eth_streamer.sv
// Directed/randomised bench: a BRAM model feeds the streamer and received bytes are
// compared with the byte order the row contents dictate.
module tb_output_matrix_eth_streamer;
  import output_matrix_pkg::*;

  localparam int NA  = 8;
  localparam int NB  = 8;
  localparam int NE  = 8;
  localparam int AW  = 3;
  localparam int RW  = NA * NE;
  localparam int RB  = RW / 8;

  logic          eth_refclk;
  logic          rst;
  logic          start;
  logic [AW:0]   num_rows;
  logic          busy, done, en_eth, we_eth, regce_eth;
  logic [AW-1:0] addr_eth;
  logic [RW-1:0] din_eth;
  logic [RW-1:0] dout_eth;
  logic [7:0]    m_tdata;
  logic          m_tvalid, m_tready, m_tlast;

  output_matrix_eth_streamer dut (
    .eth_refclk (eth_refclk),
    .rst        (rst),
    .start      (start),
    .num_rows   (num_rows),
    .busy       (busy),
    .done       (done),
    .addr_eth   (addr_eth),
    .en_eth     (en_eth),
    .we_eth     (we_eth),
    .din_eth    (din_eth),
    .regce_eth  (regce_eth),
    .dout_eth   (dout_eth),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast)
  );

  initial eth_refclk = 1'b0;
  always #5 eth_refclk = ~eth_refclk;

  // Port-B BRAM with address latch plus output register (two-cycle read).
  logic [RW-1:0] mem [NB];
  logic [RW-1:0] lat_q;
  always @(posedge eth_refclk or posedge rst) begin
    if (rst) begin
      lat_q    <= '0;
      dout_eth <= '0;
    end else begin
      if (en_eth && !we_eth) lat_q <= mem[addr_eth];
      if (regce_eth) dout_eth <= lat_q;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Results of the most recent stream() call.
  logic [7:0]    got_b[$];
  bit            got_l[$];
  logic [AW-1:0] addrs[$];
  int            done_cycle, done_cnt, unstable, busy_at0, busy_after;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: rows are clamped to the depth, each row goes out LSB byte first,
  // and only the very last byte carries tlast.
  task automatic compare_stream(input string tag, input int nr);
    logic [7:0]    exp_b[$];
    bit            exp_l[$];
    logic [RW-1:0] row;
    int            rows;
    rows = (nr > NB) ? NB : nr;
    for (int r = 0; r < rows; r++) begin
      row = mem[r];
      for (int b = 0; b < RB; b++) begin
        exp_b.push_back(row[8*b +: 8]);
        exp_l.push_back((r == rows - 1) && (b == RB - 1));
      end
    end
    check($sformatf("%s_count", tag), 64'(got_b.size()), 64'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 64'(got_b[i]), 64'(exp_b[i]));
      check($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
    end
  endtask

  // Issue start, then observe one cycle per negedge. ready_mode 0: always ready,
  // 1: random. poke_k re-pulses start at that cycle; stop_k returns early.
  task automatic stream(input int nr, input int ready_mode, input int poke_k, input int stop_k);
    bit         prev_hold;
    logic [7:0] prev_d;
    logic       prev_l;
    got_b.delete();
    got_l.delete();
    addrs.delete();
    done_cycle = -1;
    done_cnt   = 0;
    unstable   = 0;
    busy_at0   = 0;
    busy_after = -1;
    prev_hold  = 1'b0;
    prev_d     = '0;
    prev_l     = 1'b0;
    @(negedge eth_refclk);
    start    = 1'b1;
    num_rows = (AW + 1)'(nr);
    m_tready = 1'b1;
    @(negedge eth_refclk);
    start    = 1'b0;
    busy_at0 = int'(busy);
    for (int k = 0; k < 3000; k++) begin
      if (k > 0) @(negedge eth_refclk);
      if (k == stop_k) return;
      if (prev_hold && (!m_tvalid || m_tdata !== prev_d || m_tlast !== prev_l)) unstable++;
      if (en_eth) addrs.push_back(addr_eth);
      if (done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = k;
      end
      if (done_cycle >= 0 && k == done_cycle + 1) busy_after = int'(busy);
      start    = (k == poke_k);
      num_rows = (k == poke_k) ? (AW + 1)'(1) : num_rows;
      m_tready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (m_tvalid && m_tready) begin
        got_b.push_back(m_tdata);
        got_l.push_back(m_tlast);
      end
      prev_hold = m_tvalid && !m_tready;
      prev_d    = m_tdata;
      prev_l    = m_tlast;
      if (done_cycle >= 0 && k == done_cycle + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  64'(busy), 64'd0);
    check({tag, "_done"},  64'(done), 64'd0);
    check({tag, "_addr"},  64'(addr_eth), 64'd0);
    check({tag, "_en"},    64'(en_eth), 64'd0);
    check({tag, "_regce"}, 64'(regce_eth), 64'd0);
    check({tag, "_tdata"}, 64'(m_tdata), 64'd0);
    check({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    check({tag, "_tlast"}, 64'(m_tlast), 64'd0);
  endtask

  initial begin
    int nr;
    rst      = 1'b1;
    start    = 1'b0;
    num_rows = '0;
    m_tready = 1'b0;
    for (int r = 0; r < NB; r++) mem[r] = {8{8'(r)}};
    repeat (2) @(negedge eth_refclk);
    check_all_zero("reset");
    check("reset_we", 64'(we_eth), 64'd0);
    check("reset_din", 64'(din_eth), 64'd0);
    rst = 1'b0;
    @(negedge eth_refclk);

    // Two patterned rows, no backpressure.
    stream(2, 0, -1, -1);
    compare_stream("two_rows", 2);
    check("two_rows_done_cycle", 64'(done_cycle), 64'd22);
    check("two_rows_done_cnt", 64'(done_cnt), 64'd1);
    check("two_rows_busy0", 64'(busy_at0), 64'd1);
    check("two_rows_busy_after", 64'(busy_after), 64'd0);
    check("two_rows_en_cnt", 64'(addrs.size()), 64'd2);
    if (addrs.size() == 2) begin
      check("two_rows_addr0", 64'(addrs[0]), 64'd0);
      check("two_rows_addr1", 64'(addrs[1]), 64'd1);
    end
    check("two_rows_we", 64'(we_eth), 64'd0);
    check("two_rows_din", 64'(din_eth), 64'd0);

    // Zero rows: no BRAM access, no bytes, prompt done.
    stream(0, 0, -1, -1);
    check("zero_en_cnt", 64'(addrs.size()), 64'd0);
    check("zero_bytes", 64'(got_b.size()), 64'd0);
    check("zero_done_cnt", 64'(done_cnt), 64'd1);
    check("zero_done_prompt", 64'(done_cycle >= 0 && done_cycle <= 2), 64'd1);

    for (int r = 0; r < NB; r++) mem[r] = {$urandom, $urandom};

    // Oversized request is clamped to the BRAM depth.
    stream(15, 0, -1, -1);
    compare_stream("clamp", 15);
    check("clamp_en_cnt", 64'(addrs.size()), 64'd8);
    check("clamp_done_cycle", 64'(done_cycle), 64'd88);
    for (int i = 0; i < addrs.size(); i++) check($sformatf("clamp_addr%0d", i),
                                                 64'(addrs[i]), 64'(i));

    // Random backpressure.
    stream(3, 1, -1, -1);
    compare_stream("bp3", 3);
    check("bp3_stable", 64'(unstable), 64'd0);
    check("bp3_done_cnt", 64'(done_cnt), 64'd1);

    for (int t = 0; t < 3; t++) begin
      nr = $urandom_range(1, 9);
      for (int r = 0; r < NB; r++) mem[r] = {$urandom, $urandom};
      stream(nr, 1, -1, -1);
      compare_stream($sformatf("rnd%0d", t), nr);
      check($sformatf("rnd%0d_stable", t), 64'(unstable), 64'd0);
      check($sformatf("rnd%0d_done_cnt", t), 64'(done_cnt), 64'd1);
    end

    // Start re-pulsed during SEND is ignored.
    stream(2, 0, 5, -1);
    compare_stream("restart", 2);
    check("restart_done_cnt", 64'(done_cnt), 64'd1);
    check("restart_done_cycle", 64'(done_cycle), 64'd22);

    // Reset in the middle of row 1, then a clean single-row transfer.
    stream(2, 0, -1, 16);
    check("midrow_tvalid", 64'(m_tvalid), 64'd1);
    rst = 1'b1;
    @(negedge eth_refclk);
    check_all_zero("midrst");
    rst = 1'b0;
    @(negedge eth_refclk);
    stream(1, 0, -1, -1);
    compare_stream("after_rst", 1);
    check("after_rst_done_cycle", 64'(done_cycle), 64'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
